// File: rtl/spi_cmd_arbiter.sv
// ============================================================================
// Module  : spi_cmd_arbiter
// Purpose : Round-robin arbiter/sequencer sharing one SPI_driver between N_REQ
//           requesters. Optional WAIT timeout + driver abort: SPI_ARB_TIMEOUT_EN
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_cmd_arbiter #(
  parameter int N_REQ          = 4,
  parameter int PULSE_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ABORT_LEN      = 4,
  localparam int IW            = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ-1:0]   req_is_write_i,
  input  logic [8*N_REQ-1:0] req_addr_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [8*N_REQ-1:0] req_num_i,
  output logic [N_REQ-1:0]   done_o,
  output logic               done_err_o,
  output logic               busy_o,
  output logic [IW-1:0]      grant_id_o,
  output logic               drv_new_command_o,
  output logic               drv_is_write_o,
  output logic [7:0]         drv_write_register_addr_o,
  output logic [7:0]         drv_write_data_o,
  output logic [7:0]         drv_start_read_register_addr_o,
  output logic [7:0]         drv_num_regs_to_read_o,
  input  logic               drv_write_complete_i,
  input  logic               drv_read_complete_i,
  output logic               drv_rstn_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [2:0] S_ABORT = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          reject_q, reject_d;
  logic          prev_wr_q, prev_wr_d;
  logic          prev_rd_q, prev_rd_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    num_q, num_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]   to_cnt_q, to_cnt_d;
`endif

  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    scan_idx;
  logic             win_found;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] grant_oh;
  logic             complete;

  // Scan from pointer+1 so the last winner has lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req_valid_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign complete = is_wr_q ? (drv_write_complete_i & ~prev_wr_q)
                            : (drv_read_complete_i  & ~prev_rd_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    reject_d  = reject_q;
    prev_wr_d = prev_wr_q;
    prev_rd_d = prev_rd_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    num_d     = num_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = win_idx;
          ptr_d    = win_idx;
          is_wr_d  = req_is_write_i[win_idx];
          addr_d   = req_addr_i[{win_idx, 3'b000} +: 8];
          data_d   = req_data_i[{win_idx, 3'b000} +: 8];
          num_d    = req_num_i[{win_idx, 3'b000} +: 8];
          reject_d = !req_is_write_i[win_idx] &&
                     (req_num_i[{win_idx, 3'b000} +: 8] == 8'd0);
          err_d    = reject_d;
          cnt_d    = 8'd0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (reject_q) begin
          state_d = S_DONE;
        end else if (cnt_q == 8'(PULSE_LEN - 1)) begin
          // Flags already high here must not count as completion.
          prev_wr_d = drv_write_complete_i;
          prev_rd_d = drv_read_complete_i;
          state_d   = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt_d  = 16'd0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        prev_wr_d = drv_write_complete_i;
        prev_rd_d = drv_read_complete_i;
        if (complete) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = 8'd0;
          state_d = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
`ifdef SPI_ARB_TIMEOUT_EN
      S_ABORT: begin
        if (cnt_q == 8'(ABORT_LEN - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(N_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      reject_q  <= 1'b0;
      prev_wr_q <= 1'b0;
      prev_rd_q <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      num_q     <= 8'd0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      reject_q  <= reject_d;
      prev_wr_q <= prev_wr_d;
      prev_rd_q <= prev_rd_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      num_q     <= num_d;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign req_ready_o                    = (state_q == S_IDLE && win_found) ? win_oh : '0;
  assign done_o                         = (state_q == S_DONE) ? grant_oh : '0;
  assign done_err_o                     = (state_q == S_DONE) && err_q;
  assign busy_o                         = (state_q != S_IDLE);
  assign grant_id_o                     = grant_q;
  assign drv_new_command_o              = (state_q == S_ISSUE) && !reject_q;
  assign drv_is_write_o                 = is_wr_q;
  assign drv_write_register_addr_o      = addr_q;
  assign drv_write_data_o               = data_q;
  assign drv_start_read_register_addr_o = addr_q;
  assign drv_num_regs_to_read_o         = num_q;

`ifdef SPI_ARB_TIMEOUT_EN
  assign drv_rstn_o = (state_q != S_ABORT);
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES[0] ^ ABORT_LEN[0];
  assign drv_rstn_o = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_arbiter.sv
// ============================================================================
// Module  : tb_spi_cmd_arbiter
// Purpose : Directed, table-driven bench for spi_cmd_arbiter with driver model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_cmd_arbiter;

  localparam int N   = 4;
  localparam int PL  = 4;
  localparam int AL  = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 200;
`else
  localparam int TMO = 65535;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_is_write = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [8*N-1:0] req_num = '0;
  logic [N-1:0]  done;
  logic          done_err;
  logic          busy;
  logic [1:0]    grant_id;
  logic          drv_new_command;
  logic          drv_is_write;
  logic [7:0]    drv_waddr;
  logic [7:0]    drv_wdata;
  logic [7:0]    drv_raddr;
  logic [7:0]    drv_num;
  logic          wc = 1'b0;
  logic          rc = 1'b0;
  logic          drv_rstn;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         r;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] num;
    int         lat;
    bit         noise;
    bit         pre;
    bit         exp_err;
  } vec_t;

  spi_cmd_arbiter #(
    .N_REQ(N), .PULSE_LEN(PL), .TIMEOUT_CYCLES(TMO), .ABORT_LEN(AL)
  ) dut (
    .clk_i                          (clk),
    .rstn_i                         (rstn),
    .req_valid_i                    (req_valid),
    .req_ready_o                    (req_ready),
    .req_is_write_i                 (req_is_write),
    .req_addr_i                     (req_addr),
    .req_data_i                     (req_data),
    .req_num_i                      (req_num),
    .done_o                         (done),
    .done_err_o                     (done_err),
    .busy_o                         (busy),
    .grant_id_o                     (grant_id),
    .drv_new_command_o              (drv_new_command),
    .drv_is_write_o                 (drv_is_write),
    .drv_write_register_addr_o      (drv_waddr),
    .drv_write_data_o               (drv_wdata),
    .drv_start_read_register_addr_o (drv_raddr),
    .drv_num_regs_to_read_o         (drv_num),
    .drv_write_complete_i           (wc),
    .drv_read_complete_i            (rc),
    .drv_rstn_o                     (drv_rstn)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int r);
    int n;
    n = 0;
    while (req_ready === '0 && n < 50) begin
      tick();
      n++;
    end
    check("ready", req_ready, oh(r));
  endtask

  // Entered on the cycle req_ready is high (cycle 0); acts as the driver model.
  task automatic serve(input int r, input bit wr, input int lat, input bit noise,
                       input bit pre, input bit exp_err, input logic [7:0] ea,
                       input logic [7:0] ed, input logic [7:0] en, input bit drop);
    int cyc, pulses, end_cyc, flag_cyc;
    bit prev_cmd, got;
    cyc = 0; pulses = 0; end_cyc = -1; flag_cyc = -1; prev_cmd = 0; got = 0;
    while (!got && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        if (drop) req_valid[r] = 1'b0;
        check("grant_id", grant_id, r);
        check("busy", busy, 1);
        check("drv_is_write", drv_is_write, wr);
        check("drv_waddr", drv_waddr, ea);
        check("drv_raddr", drv_raddr, ea);
        check("drv_wdata", drv_wdata, ed);
        check("drv_num", drv_num, en);
      end
      if (drv_new_command) pulses++;
      if (prev_cmd && !drv_new_command) end_cyc = cyc;
      prev_cmd = drv_new_command;
      if (done !== '0) begin
        got = 1;
        check("done_vec", done, oh(r));
        check("done_err", done_err, exp_err);
        check("done_time", cyc, exp_err ? 2 : flag_cyc + 1);
      end else if (end_cyc > 0) begin
        if (noise && cyc == end_cyc + 1) begin
          if (wr) rc = 1'b1; else wc = 1'b1;
        end
        if (pre && cyc == end_cyc + 3) begin
          if (wr) wc = 1'b0; else rc = 1'b0;
        end
        if (cyc == end_cyc + lat) begin
          if (wr) wc = 1'b1; else rc = 1'b1;
          flag_cyc = cyc;
        end
      end
    end
    if (!got) check("done_seen", 0, 1);
    check("pulse_len", pulses, exp_err ? 0 : PL);
    wc = 1'b0;
    rc = 1'b0;
  endtask

  task automatic do_cmd(input vec_t v);
    req_is_write[v.r]     = v.wr;
    req_addr[8*v.r +: 8]  = v.addr;
    req_data[8*v.r +: 8]  = v.data;
    req_num[8*v.r +: 8]   = v.num;
    if (v.pre) begin
      if (v.wr) wc = 1'b1; else rc = 1'b1;
    end
    req_valid[v.r] = 1'b1;
    #1;
    wait_ready(v.r);
    serve(v.r, v.wr, v.lat, v.noise, v.pre, v.exp_err, v.addr, v.data, v.num, 1'b1);
    tick();
    check("busy_idle", busy, 0);
    check("field_hold", drv_waddr, v.addr);
  endtask

  initial begin
    vec_t tbl[6];
    int   order[5];
    tbl[0] = '{r:0, wr:1, addr:8'h12, data:8'hA5, num:8'h00, lat:100, noise:0, pre:0, exp_err:0};
    tbl[1] = '{r:1, wr:0, addr:8'h30, data:8'h00, num:8'h03, lat:20,  noise:1, pre:0, exp_err:0};
    tbl[2] = '{r:2, wr:0, addr:8'h40, data:8'h11, num:8'h00, lat:0,   noise:0, pre:0, exp_err:1};
    tbl[3] = '{r:3, wr:1, addr:8'hFF, data:8'h00, num:8'h07, lat:1,   noise:1, pre:0, exp_err:0};
    tbl[4] = '{r:0, wr:0, addr:8'h01, data:8'h99, num:8'hFF, lat:5,   noise:0, pre:0, exp_err:0};
    tbl[5] = '{r:1, wr:1, addr:8'h5A, data:8'h3C, num:8'h00, lat:50,  noise:0, pre:1, exp_err:0};
    order = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_done_err", done_err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_newcmd", drv_new_command, 0);
    check("rst_waddr", drv_waddr, 0);
    check("rst_drv_rstn", drv_rstn, 1);
    rstn = 1'b1;
    tick();

    // All requesters at once from reset: pure round-robin starting at 0
    req_is_write = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[8*i +: 8] = 8'hA0 + 8'(i);
      req_data[8*i +: 8] = 8'h50 + 8'(i);
      req_num[8*i +: 8]  = 8'h01;
    end
    req_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_ready(order[k]);
      serve(order[k], 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(order[k]),
            8'h50 + 8'(order[k]), 8'h01, 1'b0);
    end
    req_valid = '0;
    tick();

    for (int i = 0; i < 6; i++) do_cmd(tbl[i]);

    // Async reset during WAIT of requester 1
    req_is_write[1]    = 1'b1;
    req_addr[8 +: 8]   = 8'h77;
    req_valid[1]       = 1'b1;
    #1;
    wait_ready(1);
    tick();
    req_valid[1] = 1'b0;
    repeat (PL + 3) tick();
    check("wait_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_grant", grant_id, 0);
    check("arst_waddr", drv_waddr, 0);
    check("arst_newcmd", drv_new_command, 0);
    check("arst_done", done, 0);
    check("arst_drv_rstn", drv_rstn, 1);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_done_after_rst", done, 0);
    end
    req_is_write[0]  = 1'b1;
    req_addr[0 +: 8] = 8'h21;
    req_data[0 +: 8] = 8'h43;
    req_valid        = 4'b0011;
    #1;
    check("rst_rr_first", req_ready, oh(0));
    serve(0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 8'h21, 8'h43, req_num[0 +: 8], 1'b0);
    req_valid = '0;
    tick();

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int cyc, end_cyc, first_low, lows;
      bit prev_cmd, got;
      cyc = 0; end_cyc = -1; first_low = -1; lows = 0; prev_cmd = 0; got = 0;
      req_is_write[2]  = 1'b1;
      req_addr[16 +: 8] = 8'h66;
      req_valid[2]      = 1'b1;
      #1;
      wait_ready(2);
      while (!got && cyc < 600) begin
        tick();
        cyc++;
        if (cyc == 1) begin
          req_valid[2] = 1'b0;
          req_valid[0] = 1'b1;
        end
        if (prev_cmd && !drv_new_command) end_cyc = cyc;
        prev_cmd = drv_new_command;
        if (!drv_rstn) begin
          lows++;
          if (first_low < 0) first_low = cyc;
        end
        if (done !== '0) begin
          got = 1;
          check("tmo_done", done, oh(2));
          check("tmo_err", done_err, 1);
          check("tmo_done_time", cyc, end_cyc + TMO + AL);
        end
      end
      if (!got) check("tmo_done_seen", 0, 1);
      check("tmo_abort_start", first_low, end_cyc + TMO);
      check("tmo_abort_len", lows, AL);
      tick();
      check("tmo_next_ready", req_ready, oh(0));
      serve(0, 1'b1, 5, 1'b0, 1'b0, 1'b0, req_addr[0 +: 8], req_data[0 +: 8],
            req_num[0 +: 8], 1'b1);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_cmd_arbiter.md
Name: spi_cmd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one SPI_driver instance between N_REQ requesters.
- Per command: latches the winner's fields, pulses the driver's new_command for a bounded time, waits for the matching completion flag, then returns a per-requester done pulse.
- Sits between control sources (IPIF register block, autonomous readback engine, etc.) and the driver, so only one command is ever in flight.

Parameters:
N_REQ, 4, number of requesters (2..8)
PULSE_LEN, 4, cycles drv_new_command is held high per command (1..15)
TIMEOUT_CYCLES, 65535, WAIT-state cycle limit before abort (used only with SPI_ARB_TIMEOUT_EN)
ABORT_LEN, 4, cycles drv_rstn is held low on abort

Ports:
clk  in  1  IP clock (~40 MHz), same as the driver
rstn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  request pending, one bit per requester
req_ready  out  N_REQ  one-hot, one-cycle accept strobe
req_is_write  in  N_REQ  1 = write, 0 = read
req_addr  in  8*N_REQ  write addr, or start read addr; slice i = [8i+7:8i]
req_data  in  8*N_REQ  write data (ignored for reads)
req_num  in  8*N_REQ  registers to read (ignored for writes)
done  out  N_REQ  one-hot, one-cycle completion strobe to the owning requester
done_err  out  1  qualifies done: 1 = rejected or aborted
busy  out  1  high in any state except IDLE
grant_id  out  $clog2(N_REQ)  index of current or last owner
drv_new_command  out  1  to SPI_driver new_command
drv_is_write  out  1  to SPI_driver is_write
drv_write_register_addr  out  8  to SPI_driver
drv_write_data  out  8  to SPI_driver
drv_start_read_register_addr  out  8  to SPI_driver
drv_num_regs_to_read  out  8  to SPI_driver
drv_write_complete  in  1  from SPI_driver
drv_read_complete  in  1  from SPI_driver
drv_rstn  out  1  ANDed into the driver reset by the integrator; used for abort

Behaviour:
- Reset values: all outputs 0, except drv_rstn = 1. grant_id = 0. RR pointer = N_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT, DONE, ABORT.
- Arbitration (IDLE):
  - Each cycle, scan req_valid starting at pointer+1, wrapping modulo N_REQ; first set bit wins.
  - Same cycle: req_ready[win] = 1; winner's fields are latched into the drv_* registers; grant_id = win; pointer = win.
  - Handshake: a requester holds valid and fields stable until it sees ready. Fields are don't-care after ready. Dropping valid before ready withdraws the request legally.
- Read with req_num == 0:
  - Never issued. Next cycle goes to DONE with done_err = 1.
  - drv_new_command stays 0.
- ISSUE:
  - drv_new_command = 1 for exactly PULSE_LEN cycles, then 0, then go to WAIT.
  - prev_flag registers are loaded with the current completion flags on the last ISSUE cycle.
- WAIT:
  - Completion = rising edge (0 -> 1, sampled vs. prev_flag) of drv_write_complete for writes, or drv_read_complete for reads.
  - The other flag is ignored. A flag already high at ISSUE exit does not count.
  - On completion, go to DONE with err = 0.
- DONE:
  - One cycle: done[grant_id] = 1, done_err = err. Then go to IDLE.
  - Earliest next grant is the cycle after DONE. Back-to-back accept latency is PULSE_LEN + driver time + 2 cycles.
- Fairness: a requester holding valid continuously is granted within N_REQ grants.
- Drv field registers hold their values after completion until the next grant.
- Async reset mid-command: immediate return to reset values; no done pulse is issued.
- Simultaneous requests in IDLE: pure round-robin, no fixed priority.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs in WAIT. When it reaches TIMEOUT_CYCLES, go to ABORT.
  - ABORT holds drv_rstn = 0 for ABORT_LEN cycles, then goes to DONE with done_err = 1.
  - Completion seen on the same cycle as the timeout: completion wins.
- Undefined:
  - No counter and no ABORT state; WAIT can last indefinitely.
  - drv_rstn is constant 1.
  - done_err is only ever set by the req_num == 0 rejection.

Test Plan:
1. Single write, req0: addr 0x12, data 0xA5; driver model raises write_complete 100 cycles after the pulse -> req_ready[0] for 1 cycle; drv_new_command high 4 cycles; drv_write_register_addr = 0x12; done[0] = 1 with done_err = 0 exactly 1 cycle after the flag edge.
2. All 4 requesters valid simultaneously from reset, each completing -> grant order 0, 1, 2, 3, 0. Each done matches its grant_id.
3. Read on req2 with req_num = 0 -> drv_new_command never asserts; done[2] = 1 with done_err = 1 two cycles after ready.
4. write_complete already high when a new write is issued; model drops it and raises it again after 50 cycles -> done fires only after the new rising edge, not at WAIT entry.
5. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 200, driver model never completes -> drv_rstn low 4 cycles starting 200 cycles into WAIT, then done = 1 with done_err = 1. A pending requester is granted next.
6. rstn asserted during WAIT of req1 -> all outputs return to reset values asynchronously; no done[1] pulse; after release, req0 wins first.
